i2cmb_bus_monitor_mc: RTL

Parametrised multi-channel I2C bus monitor for the I2CMB multi-bus master: one instance watches all `NUM_BUSES` SCL/SDA pairs. Per bus it synchronises and deglitches both lines and detects START/STOP. It tracks bus-busy and bus-free after a programmable t_BUF, and flags arbitration loss against the master's own SDA drive. The byte/bit-level controllers and the status registers consume its per-bus outputs.

---
 rtl/i2cmb_mon_pkg.sv | 22 ++
 rtl/i2cmb_line_filter.sv | 46 ++++
 rtl/i2cmb_bus_monitor_mc.sv | 136 +++++++++++++
 3 files changed

// File: rtl/i2cmb_mon_pkg.sv
// Shared types and helpers for the I2CMB multi-bus monitor.
package i2cmb_mon_pkg;

    localparam int MAX_BUSES = 16;

    typedef enum logic [1:0] {
        IDLE_WAIT = 2'd0,
        FREE      = 2'd1,
        BUSY      = 2'd2
    } mon_state_t;

    // Smallest width w with 2**w > n, so a counter can hold the value n itself.
    function automatic int clog2_filter(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) <= n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/i2cmb_line_filter.sv
// One I2C line: 2-FF synchroniser followed by a persistence filter that
// only follows the line after FILTER_LEN consecutive disagreeing samples.
module i2cmb_line_filter
    import i2cmb_mon_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic line_f_o
);

    localparam int               CNT_W    = clog2_filter(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: all state here uses non-blocking assignments so the synchroniser
    // stages shift by exactly one register per clock regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_filt  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= line_i;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign line_f_o = r_filt;

endmodule

// File: rtl/i2cmb_bus_monitor_mc.sv
// Multi-channel I2C bus monitor: per bus START/STOP detection, busy/free
// tracking with a programmable t_BUF and arbitration-loss detection.
module i2cmb_bus_monitor_mc
    import i2cmb_mon_pkg::*;
#(
    parameter int NUM_BUSES  = 16,
    parameter int FILTER_LEN = 4,
    parameter int BUF_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_BUSES-1:0] scl_i,
    input  logic [NUM_BUSES-1:0] sda_i,
    input  logic [NUM_BUSES-1:0] sda_rel_i,
    input  logic [NUM_BUSES-1:0] own_xfer_i,
    input  logic [BUF_W-1:0]     buf_cycles_i,
    output logic [NUM_BUSES-1:0] scl_f_o,
    output logic [NUM_BUSES-1:0] sda_f_o,
    output logic [NUM_BUSES-1:0] start_o,
    output logic [NUM_BUSES-1:0] stop_o,
    output logic [NUM_BUSES-1:0] busy_o,
    output logic [NUM_BUSES-1:0] free_o,
    output logic [NUM_BUSES-1:0] arb_lost_o
);

    // Filtered lines come out of reset forced high, so they are not trusted
    // as "idle" until the synchroniser plus one filter window has elapsed.
    localparam int                WARM_CYCLES = 2 + FILTER_LEN;
    localparam int                WARM_W      = clog2_filter(WARM_CYCLES);
    localparam logic [WARM_W-1:0] WARM_DONE   = WARM_W'(WARM_CYCLES);

    if (NUM_BUSES < 1 || NUM_BUSES > MAX_BUSES) begin : g_bad_num_buses
        $error("i2cmb_bus_monitor_mc: NUM_BUSES out of range");
    end

    for (genvar g = 0; g < NUM_BUSES; g++) begin : g_bus
        logic              w_scl_f;
        logic              w_sda_f;
        logic              w_start;
        logic              w_stop;
        logic              w_scl_rise;
        logic              w_both_high;
        logic              w_arb;
        logic              r_scl_q;
        logic              r_sda_q;
        logic              r_start;
        logic              r_stop;
        logic              r_arb;
        mon_state_t        r_state;
        logic [BUF_W-1:0]  r_buf_cnt;
        logic [WARM_W-1:0] r_warm;

        i2cmb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .line_i   (scl_i[g]),
            .line_f_o (w_scl_f)
        );

        i2cmb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .line_i   (sda_i[g]),
            .line_f_o (w_sda_f)
        );

        // Requiring SCL high both before and after keeps simultaneous edges silent.
        assign w_start     =  r_sda_q & ~w_sda_f & r_scl_q & w_scl_f;
        assign w_stop      = ~r_sda_q &  w_sda_f & r_scl_q & w_scl_f;
        assign w_scl_rise  = ~r_scl_q &  w_scl_f;
        assign w_both_high =  w_scl_f &  w_sda_f;
        // An intended START/STOP is signalled by sda_rel matching the new SDA level.
        assign w_arb = own_xfer_i[g] &
                       ((w_scl_rise & sda_rel_i[g] & ~w_sda_f) |
                        ((w_start | w_stop) & (sda_rel_i[g] != w_sda_f)));

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_scl_q   <= 1'b1;
                r_sda_q   <= 1'b1;
                r_start   <= 1'b0;
                r_stop    <= 1'b0;
                r_arb     <= 1'b0;
                r_state   <= IDLE_WAIT;
                r_buf_cnt <= '0;
                r_warm    <= '0;
            end else begin
                r_scl_q <= w_scl_f;
                r_sda_q <= w_sda_f;
                r_start <= w_start;
                r_stop  <= w_stop;
                r_arb   <= w_arb;
                if (r_warm != WARM_DONE) r_warm <= r_warm + WARM_W'(1);

                case (r_state)
                    IDLE_WAIT: begin
                        if (w_start) begin
                            r_state   <= BUSY;
                            r_buf_cnt <= '0;
                        end else if (!w_both_high || r_warm != WARM_DONE) begin
                            r_buf_cnt <= '0;
                        end else if (r_buf_cnt >= buf_cycles_i) begin
                            r_state <= FREE;
                        end else begin
                            r_buf_cnt <= r_buf_cnt + BUF_W'(1);
                        end
                    end
                    FREE: begin
                        if (w_start) begin
                            r_state <= BUSY;
                        end else if (!w_both_high) begin
                            r_state   <= IDLE_WAIT;
                            r_buf_cnt <= '0;
                        end
                    end
                    BUSY: begin
                        if (w_stop) begin
                            r_state   <= IDLE_WAIT;
                            r_buf_cnt <= '0;
                        end
                    end
                    default: r_state <= IDLE_WAIT;
                endcase
            end
        end

        assign scl_f_o[g]    = w_scl_f;
        assign sda_f_o[g]    = w_sda_f;
        assign start_o[g]    = r_start;
        assign stop_o[g]     = r_stop;
        assign arb_lost_o[g] = r_arb;
        assign busy_o[g]     = (r_state == BUSY);
        assign free_o[g]     = (r_state == FREE);
    end

endmodule
